// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : EX operand forwarding selects, load-use hazard detection,
//               multi-cycle EX stall sequencer and saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter  int REG_AW     = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int FWD_STAGES = 2,
    parameter  int MC_LAT     = 4,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*REG_AW-1:0]   rs_ex,
    input  logic [NUM_SRC*REG_AW-1:0]   rs_id,
    input  logic [NUM_SRC-1:0]          rs_used_id,
    input  logic [REG_AW-1:0]           rd_ex,
    input  logic                        RUWr_ex,
    input  logic                        is_load_ex,
    input  logic                        mc_start_ex,
    input  logic [FWD_STAGES*REG_AW-1:0] rd_fwd,
    input  logic [FWD_STAGES-1:0]       RUWr_fwd,
    input  logic                        cnt_clr,
    output logic [NUM_SRC*SEL_W-1:0]    ForwardSrc,
    output logic                        stall_if,
    output logic                        stall_id,
    output logic                        stall_ex,
    output logic                        flush_ex,
    output logic                        mc_busy,
    output logic [CNT_W-1:0]            stall_cycles
);

    localparam int c_MCW = $clog2(MC_LAT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_MCW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic w_mc_stall;
    logic w_lu_en;
    logic w_hit;
    logic w_lu;

    // Scan from the oldest stage down so the youngest matching producer wins.
    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            logic [SEL_W-1:0] w_sel;
            always_comb begin
                w_sel = '0;
                for (int j = FWD_STAGES - 1; j >= 0; j--) begin
                    if (RUWr_fwd[j] && (rd_fwd[j*REG_AW +: REG_AW] != '0) &&
                        (rd_fwd[j*REG_AW +: REG_AW] == rs_ex[i*REG_AW +: REG_AW])) begin
                        w_sel = SEL_W'(j + 1);
                    end
                end
            end
            assign ForwardSrc[i*SEL_W +: SEL_W] = w_sel;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        w_mc_stall = 1'b0;
        w_lu_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc_start_ex) begin
                    w_mc_stall = 1'b1;
                    if (MC_LAT == 2) begin
                        state_d = MC_DONE;
                    end else begin
                        state_d = MC_BUSY;
                        cnt_d   = c_MCW'(MC_LAT - 3);
                    end
                end else begin
                    w_lu_en = 1'b1;
                end
            end
            MC_BUSY: begin
                w_mc_stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = MC_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MC_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_used_id[i] && (rs_id[i*REG_AW +: REG_AW] == rd_ex)) begin
                w_hit = 1'b1;
            end
        end
        w_lu = w_lu_en && RUWr_ex && is_load_ex && (rd_ex != '0) && w_hit;
    end

    // Control outputs are gated by reset so an aborted sequence drops at once.
    assign stall_if = rst_n && (w_mc_stall || w_lu);
    assign stall_id = rst_n && (w_mc_stall || w_lu);
    assign stall_ex = rst_n && w_mc_stall;
    assign flush_ex = rst_n && w_lu;
    assign mc_busy  = rst_n && (state_q != IDLE);

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (cnt_clr) begin
            stall_cycles_d = '0;
        end else if (stall_id && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule
`default_nettype wire
